// File: rtl/controller_sequencer.sv
// SAP-1 control sequencer: six-step one-hot ring plus a terminal HALT state.
// Decodes the IR opcode in T4-T6 and drives every datapath control line and alu_op.
module controller_sequencer #(
  parameter int T_STATES = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [7:0]          instr,
  output logic                pc_out,
  output logic                pc_inc,
  output logic                mar_load,
  output logic                mem_out,
  output logic                ir_load,
  output logic                ir_out,
  output logic                a_load,
  output logic                a_out,
  output logic                b_load,
  output logic                alu_out,
  output logic                out_load,
  output logic [2:0]          alu_op,
  output logic [T_STATES-1:0] t_state,
  output logic                halted
);

  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [T_STATES-1:0] ring_q, ring_d;
  logic                halt_q, halt_d;
  logic [3:0]          opc;
  logic                is_alu;
  logic                enable;
  logic                unused_operand;

  assign opc            = instr[7:4];
  assign unused_operand = ^instr[3:0];
  assign is_alu         = (opc >= OP_ADD) && (opc <= OP_XOR);
  assign enable         = rst_n && !halt_q && run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_q <= T_STATES'(1);
      halt_q <= 1'b0;
    end else begin
      ring_q <= ring_d;
      halt_q <= halt_d;
    end
  end

  // HLT leaves the ring empty so t_state reads zero for as long as we are halted.
  always_comb begin
    ring_d = ring_q;
    halt_d = halt_q;
    if (!halt_q && run) begin
      if (ring_q[T4] && (opc == OP_HLT)) begin
        ring_d = '0;
        halt_d = 1'b1;
      end else begin
        ring_d = {ring_q[T_STATES-2:0], ring_q[T_STATES-1]};
      end
    end
  end

  always_comb begin
    pc_out   = 1'b0;
    pc_inc   = 1'b0;
    mar_load = 1'b0;
    mem_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    b_load   = 1'b0;
    alu_out  = 1'b0;
    out_load = 1'b0;
    alu_op   = 3'b111;
    // alu_op stays valid through a stall so the ALU result is stable when run returns.
    if (rst_n && !halt_q && is_alu && (ring_q[T4] || ring_q[T5] || ring_q[T6])) begin
      alu_op = opc[2:0] - 3'd1;
    end
    if (enable) begin
      if (ring_q[T1]) begin
        pc_out   = 1'b1;
        mar_load = 1'b1;
      end
      if (ring_q[T2]) begin
        pc_inc = 1'b1;
      end
      if (ring_q[T3]) begin
        mem_out = 1'b1;
        ir_load = 1'b1;
      end
      if (ring_q[T4]) begin
        case (opc)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            ir_out   = 1'b1;
            mar_load = 1'b1;
          end
          OP_OUT: begin
            a_out    = 1'b1;
            out_load = 1'b1;
          end
          default: ;
        endcase
      end
      if (ring_q[T5]) begin
        if (opc == OP_LDA) begin
          mem_out = 1'b1;
          a_load  = 1'b1;
        end else if (is_alu) begin
          mem_out = 1'b1;
          b_load  = 1'b1;
        end
      end
      if (ring_q[T6] && is_alu) begin
        alu_out = 1'b1;
        a_load  = 1'b1;
      end
    end
  end

  assign t_state = ring_q;
  assign halted  = halt_q;

  // Only one driver may own the shared bus in any cycle.
  a_bus_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({pc_out, mem_out, ir_out, a_out, alu_out}));

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

Ring-counter control unit for the SAP-1 datapath. It steps through six T-states per instruction, decodes the opcode nibble held in the instruction register, and drives every datapath control line. It also supplies the 3-bit `alu_op` consumed by the ALU, so it sits directly upstream of the ALU and of the A/B registers that feed it. It halts permanently on HLT until reset.

## Interface
- `T_STATES`, 6: T-states per instruction. Fixed. The ring width is derived from it.
- `clk` input 1: single system clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `run` input 1: step enable. When low, the state holds and all control outputs are 0.
- `instr` input 8: IR contents. `[7:4]` is the opcode and `[3:0]` the operand address. It is decoded only in T4–T6.
- `pc_out`, `pc_inc`, `mar_load`, `mem_out`, `ir_load`, `ir_out`, `a_load`, `a_out`, `b_load`, `alu_out`, `out_load` output 1 each: active-high datapath controls.
- `alu_op` output 3: operation select to the ALU, encoded 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 111 pass A.
- `t_state` output 6: one-hot ring, bit0 = T1.
- `halted` output 1: high while in the HALT state.

## Operation
- **State register**
  - One-hot ring T1→T2→…→T6→T1, plus a separate HALT state.
  - It advances one step per clock while `run`=1 and holds while `run`=0.
- **Control output decode**
  - Outputs are combinational from (state, `instr[7:4]`, `run`).
  - All control outputs are forced 0 when `run`=0, when `rst_n`=0, or in HALT.
- **Fetch (every opcode)**
  - T1: `pc_out`, `mar_load`.
  - T2: `pc_inc`.
  - T3: `mem_out`, `ir_load`.
- **LDA (0000)**
  - T4: `ir_out`, `mar_load`.
  - T5: `mem_out`, `a_load`.
  - T6: idle.
- **ADD/SUB/AND/OR/XOR (0001/0010/0011/0100/0101)**
  - T4: `ir_out`, `mar_load`.
  - T5: `mem_out`, `b_load`.
  - T6: `alu_out`, `a_load`.
  - `alu_op` = opcode − 1, held stable across T4–T6.
- **OUT (1110)**
  - T4: `a_out`, `out_load`.
  - T5–T6: idle.
- **HLT (1111)**
  - T4: no controls.
  - The T4→next edge goes to HALT instead of T5.
  - HALT is left only by reset. `run` has no effect in HALT.
- **Opcodes 0110–1101**: NOP. T4–T6 idle, then return to T1.
- **`alu_op` outside an ALU instruction's T4–T6**: 3'b111.
- **Bus rule**: at most one of `pc_out`, `mem_out`, `ir_out`, `a_out`, `alu_out` is high in any cycle. This is a required assertion.

## Timing
- **Reset**
  - While `rst_n`=0, asynchronously: `t_state`=6'b000001, `halted`=0, every control output 0, `alu_op`=3'b111.
  - First active T1 is the cycle after `rst_n` rises, with `run`=1.
- **Reset mid-instruction**: the instruction is abandoned. No further control pulses are issued for it, and the next instruction restarts at T1.
- **Instruction length**: 6 clocks per instruction (LDA, ALU, OUT, NOP). HLT reaches HALT 4 clocks after its T1.
- **`instr` validity**: `instr` is valid from the cycle after the T3 edge. The decoder ignores `instr` in T1–T3.
- **`run` deasserted**
  - The current T-state is frozen. Each control pulse still fires for exactly one enabled cycle, so `pc_inc` is never duplicated.
  - The step resumes at the same T-state when `run` returns high.
- **`run`=0 at the T4 of an HLT**: no transition. HALT is entered on the first enabled T4 edge.
- **`halted`**
  - Rises in the cycle after the HLT T4 edge.
  - Stays high with `t_state`=0 until reset.

## Test plan
- **Reset**: assert `rst_n`=0 mid-clock → `t_state`=000001, `halted`=0, all controls 0, `alu_op`=111 immediately. Release → T1 asserts `pc_out`+`mar_load`.
- **LDA**: `instr`=8'h09, `run`=1 → over T1–T6: {`pc_out`,`mar_load`}, `pc_inc`, {`mem_out`,`ir_load`}, {`ir_out`,`mar_load`}, {`mem_out`,`a_load`}, none. Then T1 again.
- **ALU ops**
  - `instr`=8'h1A (ADD) → T5 has `b_load`, T6 has `alu_out`+`a_load`, `alu_op`=000 during T4–T6 and 111 otherwise.
  - Repeat with 8'h5A (XOR) → `alu_op`=100.
  - Repeat with 8'h2A (SUB) → `alu_op`=001.
- **OUT then HLT**
  - `instr`=8'hE0 → T4 has `a_out`+`out_load`.
  - Then `instr`=8'hF0 → after the T4 edge `halted`=1, `t_state`=0, no controls for 20 further cycles despite `run`=1.
- **`run` stall**: drop `run` during T2 for 3 cycles → `pc_inc` high only in the enabled T2 cycles, `t_state` frozen at 000010, resumes at T3.
- **Mid-instruction reset and bus rule**
  - Pulse `rst_n` low during T5 of an ADD → no `b_load`/`alu_out` afterwards, next cycle after release is T1.
  - Across all scenarios, the bus-exclusivity assertion never fires.
